mux_oht_pipe: RTL

// - Pipelined one-hot multiplexer: SPLIT-ary AND-OR reduction tree with one register stage per tree level.
// - Valid/ready handshake on input and output, so it sits directly in streaming datapaths.
// - Flags a zero select (nul) and a multi-hot select (err) instead of silently picking an entry.
// - Successor to the combinational one-hot mux, for WIDTHs where a single-cycle tree misses timing.

---
 rtl/mux_pkg.sv | 48 ++++
 rtl/mux_oht_node.sv | 32 +++
 rtl/mux_oht_pipe.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared sizing helpers for the pipelined one-hot multiplexer tree.
package mux_pkg;

    // Number of tree levels: smallest l with split**l >= width.
    function automatic int levels(input int width, input int split);
        int l;
        int p;
        l = 0;
        p = 1;
        if (split >= 2) begin
            while (p < width) begin
                p = p * split;
                l = l + 1;
            end
        end else begin
            l = 1;
        end
        return l;
    endfunction

    // Leaf count after zero-padding up to a full tree.
    function automatic int pad(input int width, input int split);
        int p;
        p = 1;
        for (int i = 0; i < levels(width, split); i++) begin
            p = p * split;
        end
        return p;
    endfunction

    // Flat index of the first node of tree level lvl (levels numbered from 1).
    function automatic int node_off(input int width, input int split, input int lvl);
        int off;
        int n;
        off = 0;
        n   = pad(width, split);
        for (int k = 1; k < lvl; k++) begin
            n   = n / split;
            off = off + n;
        end
        return off;
    endfunction

    function automatic int node_cnt(input int width, input int split);
        return node_off(width, split, levels(width, split) + 1);
    endfunction

endpackage

// File: rtl/mux_oht_node.sv
// One SPLIT-input node of the one-hot AND-OR tree: merges select, data and
// multi-hot error of its children.
module mux_oht_node #(
    parameter int  SPLIT = 4,
    parameter type DAT_T = logic [7:0]
) (
    input  logic [SPLIT-1:0] c_sel,
    input  DAT_T             c_dat [SPLIT],
    input  logic [SPLIT-1:0] c_err,
    output logic             sel,
    output DAT_T             dat,
    output logic             err
);

    logic seen_s;
    logic multi_s;

    // AND-OR data merge; a second set select bit marks the node multi-hot.
    always_comb begin
        dat     = '0;
        seen_s  = 1'b0;
        multi_s = 1'b0;
        for (int k = 0; k < SPLIT; k++) begin
            dat     = dat | (c_sel[k] ? c_dat[k] : '0);
            multi_s = multi_s | (seen_s & c_sel[k]);
            seen_s  = seen_s | c_sel[k];
        end
        sel = seen_s;
        err = (|c_err) | multi_s;
    end

endmodule

// File: rtl/mux_oht_pipe.sv
// Pipelined one-hot multiplexer: one register stage per tree level with
// valid/ready flow control and bubble collapsing between stages.
module mux_oht_pipe
    import mux_pkg::*;
#(
    parameter type DAT_T = logic [7:0],
    parameter int  WIDTH = 16,
    parameter int  SPLIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_vld,
    output logic             i_rdy,
    input  logic [WIDTH-1:0] i_oht,
    input  DAT_T             i_ary [WIDTH-1:0],
    output logic             o_vld,
    input  logic             o_rdy,
    output DAT_T             o_dat,
    output logic             o_nul,
    output logic             o_err
);

    localparam int LEVELS = levels(WIDTH, SPLIT);
    localparam int PAD    = pad(WIDTH, SPLIT);
    localparam int NODES  = node_cnt(WIDTH, SPLIT);
    localparam int ROOT   = NODES - 1;

    if (WIDTH < 2 || SPLIT < 2) begin : g_bad_param
        $fatal(1, "mux_oht_pipe: WIDTH and SPLIT must both be >= 2");
    end

    logic [PAD-1:0]    leaf_sel_s;
    DAT_T              leaf_dat_s [PAD];
    logic [NODES-1:0]  node_sel_s;
    logic [NODES-1:0]  node_err_s;
    DAT_T              node_dat_s [NODES];
    logic [NODES-1:0]  ld_s;

    // Node registers keep nul (not sel) so that reset leaves o_nul low.
    logic [NODES-1:0]  nul_q, nul_d;
    logic [NODES-1:0]  err_q, err_d;
    DAT_T              dat_q [NODES];
    DAT_T              dat_d [NODES];
    logic [LEVELS-1:0] vld_q, vld_d;
    logic [LEVELS-1:0] rdy_s;
    logic [LEVELS-1:0] vin_s;
    logic              free_s;

    for (genvar i = 0; i < PAD; i++) begin : g_leaf
        if (i < WIDTH) begin : g_real
            assign leaf_sel_s[i] = i_oht[i];
            assign leaf_dat_s[i] = i_ary[i];
        end else begin : g_zero
            assign leaf_sel_s[i] = 1'b0;
            assign leaf_dat_s[i] = '0;
        end
    end

    for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
        localparam int NL  = PAD / (SPLIT ** l);
        localparam int OFF = node_off(WIDTH, SPLIT, l);
        for (genvar j = 0; j < NL; j++) begin : g_node
            logic [SPLIT-1:0] c_sel;
            logic [SPLIT-1:0] c_err;
            DAT_T             c_dat [SPLIT];
            for (genvar k = 0; k < SPLIT; k++) begin : g_ch
                if (l == 1) begin : g_from_leaf
                    assign c_sel[k] = leaf_sel_s[j*SPLIT + k];
                    assign c_dat[k] = leaf_dat_s[j*SPLIT + k];
                    assign c_err[k] = 1'b0;
                end else begin : g_from_reg
                    localparam int C = node_off(WIDTH, SPLIT, l - 1) + j*SPLIT + k;
                    assign c_sel[k] = ~nul_q[C];
                    assign c_dat[k] = dat_q[C];
                    assign c_err[k] = err_q[C];
                end
            end
            mux_oht_node #(
                .SPLIT (SPLIT),
                .DAT_T (DAT_T)
            ) u_node (
                .c_sel (c_sel),
                .c_dat (c_dat),
                .c_err (c_err),
                .sel   (node_sel_s[OFF + j]),
                .dat   (node_dat_s[OFF + j]),
                .err   (node_err_s[OFF + j])
            );
            // Data regs only toggle when a valid item actually enters the stage.
            assign ld_s[OFF + j] = rdy_s[l-1] & vin_s[l-1];
        end
    end

    // Stage ready chain from the output back: a stage may load if it or any later stage is empty.
    always_comb begin
        free_s   = o_rdy;
        rdy_s    = '0;
        vin_s    = '0;
        vin_s[0] = i_vld;
        for (int s = LEVELS - 1; s >= 0; s--) begin
            free_s   = free_s | ~vld_q[s];
            rdy_s[s] = free_s;
        end
        for (int s = 1; s < LEVELS; s++) begin
            vin_s[s] = vld_q[s-1];
        end
        for (int s = 0; s < LEVELS; s++) begin
            vld_d[s] = rdy_s[s] ? vin_s[s] : vld_q[s];
        end
    end

    // Next-state of per-node payload registers.
    always_comb begin
        for (int g = 0; g < NODES; g++) begin
            nul_d[g] = ld_s[g] ? ~node_sel_s[g] : nul_q[g];
            err_d[g] = ld_s[g] ? node_err_s[g]  : err_q[g];
            dat_d[g] = ld_s[g] ? node_dat_s[g]  : dat_q[g];
        end
    end

    // Pipeline state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            nul_q <= '0;
            err_q <= '0;
            for (int g = 0; g < NODES; g++) begin
                dat_q[g] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            nul_q <= nul_d;
            err_q <= err_d;
            for (int g = 0; g < NODES; g++) begin
                dat_q[g] <= dat_d[g];
            end
        end
    end

    assign i_rdy = rdy_s[0];
    assign o_vld = vld_q[LEVELS-1];
    assign o_dat = dat_q[ROOT];
    assign o_nul = nul_q[ROOT];
    assign o_err = err_q[ROOT];

endmodule
